// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Brief    : Pipelined integer ALU with the carry chain split into SEG-bit
//             segments, one register stage per segment, valid/ready on both
//             sides.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic             cout,
    output logic             zf,
    output logic             nf,
    output logic             vf
);

    localparam int c_NSEG = WIDTH / SEG;
    localparam int c_SHW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLL = 3'b101;
    localparam logic [2:0] c_OP_SRL = 3'b110;
    localparam logic [2:0] c_OP_ADC = 3'b111;

    // r_* index k holds what stage k produced; stage k reads index k-1.
    logic [c_NSEG-1:0][WIDTH-1:0] r_a, r_bx, r_x;
    logic [c_NSEG-1:0]            r_c, r_ar, r_v;
    logic                         r_zf, r_nf, r_vf;

    logic [c_NSEG-1:0][WIDTH-1:0] w_a, w_bx, w_x, w_xn;
    logic [c_NSEG-1:0][SEG-1:0]   w_sum;
    logic [c_NSEG-1:0]            w_c, w_ar, w_v, w_cn;
    logic [WIDTH-1:0]             w_bx0, w_x0;
    logic                         w_c0, w_ar0;
    logic                         w_stall;
    logic                         w_unused;

    assign w_stall   = r_v[c_NSEG-1] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_v[c_NSEG-1];
    assign X         = r_x[c_NSEG-1];
    assign cout      = r_c[c_NSEG-1];
    assign zf        = r_zf;
    assign nf        = r_nf;
    assign vf        = r_vf;

    // Operand A and Bx of the final stage are only needed up to that stage.
    assign w_unused = ^{r_a[c_NSEG-1], r_bx[c_NSEG-1], r_ar[c_NSEG-1]};

    always_comb begin
        w_bx0 = B;
        w_c0  = 1'b0;
        w_ar0 = 1'b1;
        w_x0  = '0;
        case (op)
            c_OP_ADD: w_c0 = 1'b0;
            c_OP_SUB: begin
                w_bx0 = ~B;
                w_c0  = 1'b1;
            end
            c_OP_ADC: w_c0 = cin;
            c_OP_AND: begin w_ar0 = 1'b0; w_x0 = A & B; end
            c_OP_OR:  begin w_ar0 = 1'b0; w_x0 = A | B; end
            c_OP_XOR: begin w_ar0 = 1'b0; w_x0 = A ^ B; end
            c_OP_SLL: begin w_ar0 = 1'b0; w_x0 = A << B[c_SHW-1:0]; end
            c_OP_SRL: begin w_ar0 = 1'b0; w_x0 = A >> B[c_SHW-1:0]; end
        endcase
    end

    always_comb begin
        w_a[0]  = A;
        w_bx[0] = w_bx0;
        w_x[0]  = w_x0;
        w_c[0]  = w_c0;
        w_ar[0] = w_ar0;
        w_v[0]  = in_valid;
        for (int k = 1; k < c_NSEG; k++) begin
            w_a[k]  = r_a[k-1];
            w_bx[k] = r_bx[k-1];
            w_x[k]  = r_x[k-1];
            w_c[k]  = r_c[k-1];
            w_ar[k] = r_ar[k-1];
            w_v[k]  = r_v[k-1];
        end
        // Non-arithmetic results pass through untouched with a zero carry.
        for (int k = 0; k < c_NSEG; k++) begin
            {w_cn[k], w_sum[k]} = {1'b0, w_a[k][k*SEG +: SEG]}
                                + {1'b0, w_bx[k][k*SEG +: SEG]}
                                + {{SEG{1'b0}}, w_c[k]};
            w_xn[k] = w_x[k];
            if (w_ar[k]) begin
                w_xn[k][k*SEG +: SEG] = w_sum[k];
            end else begin
                w_cn[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_bx <= '0;
            r_x  <= '0;
            r_c  <= '0;
            r_ar <= '0;
            r_v  <= '0;
            r_zf <= 1'b0;
            r_nf <= 1'b0;
            r_vf <= 1'b0;
        end else if (!w_stall) begin
            r_a  <= w_a;
            r_bx <= w_bx;
            r_x  <= w_xn;
            r_c  <= w_cn;
            r_ar <= w_ar;
            r_v  <= w_v;
            r_zf <= (w_xn[c_NSEG-1] == '0);
            r_nf <= w_xn[c_NSEG-1][WIDTH-1];
            r_vf <= w_ar[c_NSEG-1]
                    && (w_a[c_NSEG-1][WIDTH-1] == w_bx[c_NSEG-1][WIDTH-1])
                    && (w_xn[c_NSEG-1][WIDTH-1] != w_a[c_NSEG-1][WIDTH-1]);
        end
    end

endmodule
`default_nettype wire
